// File: rtl/sram_sync_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_sync_pkg : shared state encodings, defaults and lane helper   |
// | Revision      : 1.0                                                |
// +--------------------------------------------------------------------+
package sram_sync_pkg;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 10;

  function automatic int lane_count(input int dw);
    return dw / 8;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sram_array.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_array : 2^AW x DW storage, byte-masked write, registered read |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module sram_array
  import sram_sync_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int AW    = DEF_AW,
  parameter int LANES = lane_count(DW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_we,
  input  logic [LANES-1:0] i_be,
  input  logic             i_re,
  input  logic [AW-1:0]    i_addr,
  input  logic [DW-1:0]    i_wdata,
  output logic [DW-1:0]    o_rdata,
  output logic             o_rvalid
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;
  logic          r_rvalid;

  // Storage has no reset so it maps onto plain RAM macros.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (i_be[i]) begin
          r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end
    end
  end

  // A write lands in r_mem at its own edge, so a read issued on the
  // following edge already sees the new word without a bypass path.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= i_re;
      if (i_re) begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata  = r_rdata;
  assign o_rvalid = r_rvalid;

endmodule
`default_nettype wire

// File: rtl/sram_sync.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sram_sync : synchronous single-port SRAM with byte enables,        |
// |             power-up zero sweep and optional output register       |
// | Revision  : 1.0                                                    |
// +--------------------------------------------------------------------+
module sram_sync
  import sram_sync_pkg::*;
#(
  parameter int DW         = DEF_DW,
  parameter int AW         = DEF_AW,
  parameter int OUT_REG    = 0,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              we,
  input  logic [DW/8-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [DW-1:0]     wdata,
  output logic [DW-1:0]     rdata,
  output logic              rvalid,
  output logic              ready
);

  localparam int            LANES    = lane_count(DW);
  localparam logic [AW-1:0] CNT_LAST = '1;

  state_e            r_state;
  logic [AW-1:0]     r_cnt;

  logic              w_sweep;
  logic              w_wr;
  logic              w_rd;
  logic [AW-1:0]     w_addr;
  logic [LANES-1:0]  w_be;
  logic [DW-1:0]     w_wdata;
  logic [DW-1:0]     w_arr_rdata;
  logic              w_arr_rvalid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
      if (INIT_CLEAR != 0) begin
        r_state <= ST_INIT;
      end else begin
        r_state <= ST_READY;
      end
    end else begin
      case (r_state)
        ST_INIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= ST_READY;
          end
        end
        default: r_state <= ST_READY;
      endcase
    end
  end

  // Sweep writes take the port ahead of any user request; cs is ignored
  // until the sweep completes.
  assign w_sweep = rst_n && (r_state == ST_INIT);
  assign w_wr    = w_sweep || (rst_n && (r_state == ST_READY) && cs && we);
  assign w_rd    = rst_n && (r_state == ST_READY) && cs && !we;
  assign w_addr  = w_sweep ? r_cnt : addr;
  assign w_be    = w_sweep ? {LANES{1'b1}} : be;
  assign w_wdata = w_sweep ? {DW{1'b0}} : wdata;

  sram_array #(
    .DW    (DW),
    .AW    (AW),
    .LANES (LANES)
  ) u_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_wr),
    .i_be     (w_be),
    .i_re     (w_rd),
    .i_addr   (w_addr),
    .i_wdata  (w_wdata),
    .o_rdata  (w_arr_rdata),
    .o_rvalid (w_arr_rvalid)
  );

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DW-1:0] r_rdata_q;
      logic          r_rvalid_q;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_rdata_q  <= '0;
          r_rvalid_q <= 1'b0;
        end else begin
          r_rvalid_q <= w_arr_rvalid;
          if (w_arr_rvalid) begin
            r_rdata_q <= w_arr_rdata;
          end
        end
      end

      assign rdata  = r_rdata_q;
      assign rvalid = r_rvalid_q;
    end else begin : g_no_out_reg
      assign rdata  = w_arr_rdata;
      assign rvalid = w_arr_rvalid;
    end
  endgenerate

  assign ready = (r_state == ST_READY);

endmodule
`default_nettype wire
